fifo_req_arbiter: RTL and testbench

Round-robin arbiter and response router that shares the single write port of one `fifo_oneclock` instance among `NREQ` requesters. It returns each result popped from the FIFO read side to the requester that issued it. Because the FIFO preserves order, a requester-ID tag queue inside this block tracks outstanding transactions, and the queue depth bounds how many can be in flight. The block sits between the core-side requesters and the FIFO/mock-CPU datapath, all on one clock.

---
 rtl/fifo_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fifo_req_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_req_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_req_arbiter
//
// Shares the single write port of one FIFO among NREQ requesters using a
// round-robin arbiter, and routes every word popped from the FIFO read side
// back to the requester that issued it. The FIFO keeps order, so a small
// queue of requester IDs (tags) is enough to know who owns the head result.
// The tag queue depth bounds the number of transactions in flight.
//
// Handshake: a requester transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is a one-hot grant; it is only ever
// raised for a requester whose req_valid is high. resp_valid is a one-hot,
// single-cycle strobe with no backpressure; resp_data is qualified by it.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   req_valid/req_data  per-requester request; lane i at [i*DW +: DW]
//   req_ready           one-hot grant
//   resp_valid          one-hot response strobe
//   resp_data           response payload
//   fifo_winc/wdata     FIFO write port (driven by the grant)
//   fifo_wfull          FIFO full
//   fifo_rinc           FIFO pop, asserted whenever the FIFO holds data
//   fifo_rdata/rempty   FIFO show-ahead read side
//   outstanding         tags currently in flight
//   err                 sticky: FIFO popped while no tag was outstanding
// -----------------------------------------------------------------------------
module fifo_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*DW-1:0]             req_data,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                resp_valid,
  output logic [DW-1:0]                  resp_data,
  output logic                           fifo_winc,
  output logic [DW-1:0]                  fifo_wdata,
  input  logic                           fifo_wfull,
  output logic                           fifo_rinc,
  input  logic [DW-1:0]                  fifo_rdata,
  input  logic                           fifo_rempty,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  localparam logic [CW-1:0] TAG_DEPTH_C = CW'(TAG_DEPTH);
  localparam logic [PW-1:0] LAST_REQ    = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_C      = (PW + 1)'(NREQ);

  // State
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] tag_mem_q [TAG_DEPTH];
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_data_q;
  logic            err_q, err_d;

  // Combinational arbitration / read side
  logic            can_issue;
  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;
  logic [PW:0]     cand;
  logic            pop;
  logic            pop_tag;
  logic            pop_err;
  logic [PW-1:0]   head_tag;

  // Round-robin search starting at rr_ptr. cand is one bit wider than the
  // pointer so rr_ptr + k (< 2*NREQ) can be folded back with one subtract,
  // which keeps non-power-of-two NREQ correct.
  always_comb begin
    can_issue = !fifo_wfull && (count_q < TAG_DEPTH_C) && !rst;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, rr_ptr_q} + (PW + 1)'(k);
        if (cand >= NREQ_C) begin
          cand = cand - NREQ_C;
        end
        if (!grant_any && req_valid[cand[PW-1:0]]) begin
          grant_any               = 1'b1;
          grant_idx               = cand[PW-1:0];
          grant[cand[PW-1:0]]     = 1'b1;
        end
      end
    end
  end

  assign req_ready  = grant;
  assign fifo_winc  = grant_any;
  assign fifo_wdata = grant_any ? req_data[grant_idx*DW +: DW] : '0;

  // The FIFO is drained unconditionally; responses have no backpressure.
  assign pop      = !fifo_rempty && !rst;
  assign pop_tag  = pop && (count_q != '0);
  assign pop_err  = pop && (count_q == '0);
  assign head_tag = tag_mem_q[rd_ptr_q];
  assign fifo_rinc = pop;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + PW'(1);
    end

    count_d = count_q;
    case ({grant_any, pop_tag})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    resp_valid_d = '0;
    if (pop_tag) begin
      resp_valid_d[head_tag] = 1'b1;
    end

    err_d = err_q | pop_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      if (grant_any) begin
        tag_mem_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q            <= wr_ptr_q + TW'(1);
      end
      if (pop_tag) begin
        rd_ptr_q    <= rd_ptr_q + TW'(1);
        resp_data_q <= fifo_rdata;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign outstanding = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fifo_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_req_arbiter
//
// Drives fifo_req_arbiter either against a behavioural FIFO + mock-CPU stage
// (result = upper half + lower half of the written word, configurable
// latency) or against directly driven stub FIFO flags.
// -----------------------------------------------------------------------------
module tb_fifo_req_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 32;
  localparam int TAG_DEPTH = 8;
  localparam int CW        = $clog2(TAG_DEPTH + 1);

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               fifo_winc;
  logic [DW-1:0]      fifo_wdata;
  logic               fifo_wfull;
  logic               fifo_rinc;
  logic [DW-1:0]      fifo_rdata;
  logic               fifo_rempty;
  logic [CW-1:0]      outstanding;
  logic               err;

  fifo_req_arbiter #(.NREQ(NREQ), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .fifo_winc   (fifo_winc),
    .fifo_wdata  (fifo_wdata),
    .fifo_wfull  (fifo_wfull),
    .fifo_rinc   (fifo_rinc),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .outstanding (outstanding),
    .err         (err)
  );

  // ---------------------------------------------------------------- FIFO side
  logic          stub;
  logic          stub_rempty, stub_wfull;
  logic [DW-1:0] stub_rdata;
  logic          force_wfull;
  int            lat;
  logic          sb_en;

  logic [DW-1:0] mq[$];
  int            mt[$];
  int            cyc_cnt = 0;
  logic          m_rempty = 1'b1;
  logic          m_full   = 1'b0;
  logic [DW-1:0] m_rdata  = '0;

  assign fifo_rempty = stub ? stub_rempty : m_rempty;
  assign fifo_rdata  = stub ? stub_rdata  : m_rdata;
  assign fifo_wfull  = stub ? stub_wfull  : (m_full || force_wfull);

  function automatic logic [DW-1:0] cpu_f(input logic [DW-1:0] x);
    return {16'h0, x[31:16]} + {16'h0, x[15:0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mt.delete();
    end else if (!stub) begin
      if (fifo_rinc && mq.size() > 0) begin
        void'(mq.pop_front());
        void'(mt.pop_front());
      end
      if (fifo_winc) begin
        mq.push_back(cpu_f(fifo_wdata));
        mt.push_back(cyc_cnt);
      end
    end
    cyc_cnt++;
    if (mq.size() > 0) begin
      m_rempty <= !((cyc_cnt - mt[0]) >= lat);
      m_rdata  <= mq[0];
    end else begin
      m_rempty <= 1'b1;
      m_rdata  <= '0;
    end
    m_full <= (mq.size() >= 16);
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [33:0] exp_q[$];
  int          grant_log[$];
  int          gcount = 0;
  int          resp_total = 0;
  int          resp_cnt[NREQ];
  logic [33:0] sb_e;
  int          sb_gid;

  initial begin
    for (int i = 0; i < NREQ; i++) resp_cnt[i] = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (resp_valid != '0) begin
        resp_total++;
        for (int i = 0; i < NREQ; i++) if (resp_valid[i]) resp_cnt[i]++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            check_eq("resp_unexpected", 64'(resp_valid), 64'h0);
          end else begin
            sb_e = exp_q.pop_front();
            check_eq("resp_route", 64'(resp_valid), 64'(4'b0001 << sb_e[33:32]));
            check_eq("resp_data", 64'(resp_data), 64'(sb_e[31:0]));
          end
        end
      end
      if (req_ready != '0) begin
        sb_gid = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) sb_gid = i;
        grant_log.push_back(sb_gid);
        gcount++;
        if (sb_en) exp_q.push_back({2'(sb_gid), cpu_f(fifo_wdata)});
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && outstanding == '0) break;
      tick(1);
    end
    check_eq("drain_outstanding", 64'(outstanding), 64'h0);
    check_eq("drain_exp_q", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  int r0, c0, o_prev, both_cnt;
  logic w_prev, r_prev;

  initial begin
    rst = 1'b1; req_valid = '1; req_data = '0;
    stub = 1'b1; stub_rempty = 1'b0; stub_wfull = 1'b0; stub_rdata = '0;
    force_wfull = 1'b0; lat = 1; sb_en = 1'b0;

    // Reset values, with requests and a non-empty FIFO present
    tick(2); #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'h0);
    check_eq("rst_winc", 64'(fifo_winc), 64'h0);
    check_eq("rst_rinc", 64'(fifo_rinc), 64'h0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'h0);
    check_eq("rst_resp_data", 64'(resp_data), 64'h0);
    check_eq("rst_outstanding", 64'(outstanding), 64'h0);
    check_eq("rst_err", 64'(err), 64'h0);

    // Single request through FIFO + mock CPU
    stub = 1'b0; sb_en = 1'b1; lat = 1; stub_rempty = 1'b1;
    do_reset();
    r0 = resp_total; c0 = resp_cnt[2];
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'h0005_0007;
    #1;
    check_eq("single_ready", 64'(req_ready), 64'h4);
    check_eq("single_winc", 64'(fifo_winc), 64'h1);
    check_eq("single_wdata", 64'(fifo_wdata), 64'h0005_0007);
    tick(1);
    req_valid = '0;
    tick(6);
    check_eq("single_resp_cnt", 64'(resp_cnt[2] - c0), 64'h1);
    check_eq("single_resp_total", 64'(resp_total - r0), 64'h1);
    check_eq("single_resp_data", 64'(resp_data), 64'h0000_000C);
    check_eq("single_outstanding", 64'(outstanding), 64'h0);
    check_eq("single_err", 64'(err), 64'h0);

    // Fairness: all requesters always valid
    do_reset();
    grant_log.delete(); gcount = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      tick(1);
    end
    req_valid = '0;
    check_eq("fair_gcount", 64'(gcount), 64'd12);
    for (int k = 0; k < 12; k++) begin
      if (k < grant_log.size()) check_eq("fair_order", 64'(grant_log[k]), 64'(k % 4));
    end
    drain();

    // Credit limit with a FIFO that never returns data
    stub = 1'b1; sb_en = 1'b0; stub_rempty = 1'b1; stub_wfull = 1'b0;
    do_reset();
    gcount = 0;
    req_valid = 4'b0001; req_data = '0;
    tick(12); #1;
    check_eq("credit_gcount", 64'(gcount), 64'd8);
    check_eq("credit_outstanding", 64'(outstanding), 64'd8);
    check_eq("credit_ready_low", 64'(req_ready), 64'h0);
    stub_rempty = 1'b0; stub_rdata = 32'h0000_ABCD;
    #1;
    check_eq("credit_pop_no_grant", 64'(req_ready), 64'h0);
    check_eq("credit_pop_rinc", 64'(fifo_rinc), 64'h1);
    tick(1);
    stub_rempty = 1'b1; gcount = 0;
    #1;
    check_eq("credit_resp_valid", 64'(resp_valid), 64'h1);
    check_eq("credit_resp_data", 64'(resp_data), 64'h0000_ABCD);
    check_eq("credit_after_pop", 64'(outstanding), 64'd7);
    check_eq("credit_regrant", 64'(req_ready), 64'h1);
    tick(5);
    check_eq("credit_one_more", 64'(gcount), 64'd1);
    check_eq("credit_full_again", 64'(outstanding), 64'd8);
    check_eq("credit_err", 64'(err), 64'h0);

    // Wrap-around: 40 random transactions, FIFO latency 3
    stub = 1'b0; sb_en = 1'b1; lat = 3;
    do_reset();
    gcount = 0; r0 = resp_total;
    for (int i = 0; i < 200; i++) begin
      if (gcount >= 40) break;
      req_valid = 4'($urandom_range(1, 15));
      rand_data();
      tick(1);
    end
    req_valid = '0;
    check_eq("wrap_gcount", 64'(gcount), 64'd40);
    drain();
    check_eq("wrap_resp_total", 64'(resp_total - r0), 64'd40);
    check_eq("wrap_err", 64'(err), 64'h0);

    // Full FIFO for 5 cycles, then push/pop accounting
    do_reset();
    req_valid = 4'b1111;
    rand_data();
    tick(3);
    force_wfull = 1'b1; r0 = resp_total;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("wfull_winc", 64'(fifo_winc), 64'h0);
      check_eq("wfull_ready", 64'(req_ready), 64'h0);
      tick(1);
    end
    check_eq("wfull_pops_continue", 64'(resp_total - r0), 64'd3);
    force_wfull = 1'b0;
    #1;
    check_eq("wfull_ptr_held", 64'(req_ready), 64'h8);
    both_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      w_prev = fifo_winc; r_prev = fifo_rinc; o_prev = int'(outstanding);
      if (w_prev && r_prev) both_cnt++;
      rand_data();
      tick(1); #1;
      check_eq("acct_outstanding", 64'(outstanding),
               64'(o_prev + int'(w_prev) - int'(r_prev)));
    end
    check_eq("acct_overlap_seen", 64'(both_cnt > 0), 64'h1);
    req_valid = '0;
    drain();

    // Protocol error, then reset mid-traffic
    stub = 1'b1; sb_en = 1'b0; stub_rempty = 1'b1;
    do_reset();
    stub_rempty = 1'b0; stub_rdata = 32'h1234_5678;
    #1;
    check_eq("err_pop_rinc", 64'(fifo_rinc), 64'h1);
    check_eq("err_before", 64'(err), 64'h0);
    tick(1);
    stub_rempty = 1'b1;
    #1;
    check_eq("err_set", 64'(err), 64'h1);
    check_eq("err_no_resp", 64'(resp_valid), 64'h0);
    tick(2);
    check_eq("err_sticky", 64'(err), 64'h1);
    stub = 1'b0; sb_en = 1'b1; lat = 1;
    req_valid = 4'b1111;
    rand_data();
    tick(4);
    rst = 1'b1;
    #1;
    check_eq("midrst_req_ready", 64'(req_ready), 64'h0);
    check_eq("midrst_winc", 64'(fifo_winc), 64'h0);
    check_eq("midrst_rinc", 64'(fifo_rinc), 64'h0);
    check_eq("midrst_resp_valid", 64'(resp_valid), 64'h0);
    check_eq("midrst_resp_data", 64'(resp_data), 64'h0);
    check_eq("midrst_outstanding", 64'(outstanding), 64'h0);
    check_eq("midrst_err", 64'(err), 64'h0);
    req_valid = '0;
    tick(2);
    rst = 1'b0;
    c0 = resp_cnt[1];
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 32'h0001_0002;
    tick(1);
    req_valid = '0;
    drain();
    check_eq("post_rst_resp_cnt", 64'(resp_cnt[1] - c0), 64'h1);
    check_eq("post_rst_resp_data", 64'(resp_data), 64'h3);
    check_eq("post_rst_err", 64'(err), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
